// File: rtl/ex_branch_stage.sv
// rtl/ex_branch_stage.sv - EX/MEM boundary: branch resolution, PC redirect, EX/MEM register
//
// Resolves conditional branches and jumps from the ALU flags, issues a
// registered one-cycle redirect, selects the write-back value and holds the
// EX/MEM pipeline register under stall, flush and wrong-path squash.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ex_*                        instruction currently in EX (pc, imm, class, controls)
//   alu_out, alu_zero_flag, alu_lt   ALU result and flags
//   stall, flush                hold everything / kill EX and MEM contents
//   ex_ready                    combinational !stall
//   redirect_valid, redirect_pc one-cycle fetch redirect and its target
//   mem_*                       registered EX/MEM pipeline register
module ex_branch_stage #(
  parameter int WORD_SIZE = 32,
  parameter int REG_ADDR  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [WORD_SIZE-1:0] ex_pc,
  input  logic [WORD_SIZE-1:0] ex_imm,
  input  logic [WORD_SIZE-1:0] alu_out,
  input  logic                 alu_zero_flag,
  input  logic                 alu_lt,
  input  logic                 ex_branch,
  input  logic                 ex_jal,
  input  logic                 ex_jalr,
  input  logic [2:0]           ex_funct3,
  input  logic [REG_ADDR-1:0]  ex_rd,
  input  logic                 ex_reg_write,
  input  logic                 ex_mem_read,
  input  logic                 ex_mem_write,
  input  logic [WORD_SIZE-1:0] ex_store_data,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 ex_ready,
  output logic                 redirect_valid,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 mem_valid,
  output logic [WORD_SIZE-1:0] mem_result,
  output logic [WORD_SIZE-1:0] mem_store_data,
  output logic [REG_ADDR-1:0]  mem_rd,
  output logic [2:0]           mem_funct3,
  output logic                 mem_reg_write,
  output logic                 mem_mem_read,
  output logic                 mem_mem_write
);

  logic                 r_squash_pending;
  logic                 r_redirect_valid;
  logic [WORD_SIZE-1:0] r_redirect_pc;
  logic                 r_mem_valid;
  logic [WORD_SIZE-1:0] r_mem_result;
  logic [WORD_SIZE-1:0] r_mem_store_data;
  logic [REG_ADDR-1:0]  r_mem_rd;
  logic [2:0]           r_mem_funct3;
  logic                 r_mem_reg_write;
  logic                 r_mem_mem_read;
  logic                 r_mem_mem_write;

  logic                 w_accept;
  logic                 w_taken;
  logic                 w_redirect;
  logic [WORD_SIZE-1:0] w_pc_plus_imm;
  logic [WORD_SIZE-1:0] w_pc_plus_4;
  logic [WORD_SIZE-1:0] w_target;
  logic [WORD_SIZE-1:0] w_result;

  assign w_accept = ex_valid & ~stall & ~flush & ~r_squash_pending;

  // BEQ/BNE use the SUB zero flag; the ordered compares use the SLT/SLTU bit.
  always_comb begin
    w_taken = 1'b0;
    case (ex_funct3)
      3'b000:  w_taken = alu_zero_flag;
      3'b001:  w_taken = ~alu_zero_flag;
      3'b100,
      3'b110:  w_taken = alu_lt;
      3'b101,
      3'b111:  w_taken = ~alu_lt;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_redirect    = w_accept & (ex_jal | ex_jalr | (ex_branch & w_taken));
  assign w_pc_plus_imm = ex_pc + ex_imm;
  assign w_pc_plus_4   = ex_pc + WORD_SIZE'(4);
  // JALR target is rs1+imm from the ALU with the low bit forced to zero.
  assign w_target      = ex_jalr ? {alu_out[WORD_SIZE-1:1], 1'b0} : w_pc_plus_imm;
  assign w_result      = (ex_jal | ex_jalr) ? w_pc_plus_4 : alu_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_squash_pending <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_mem_valid      <= 1'b0;
      r_mem_result     <= '0;
      r_mem_store_data <= '0;
      r_mem_rd         <= '0;
      r_mem_funct3     <= '0;
      r_mem_reg_write  <= 1'b0;
      r_mem_mem_read   <= 1'b0;
      r_mem_mem_write  <= 1'b0;
    end else if (flush) begin
      r_squash_pending <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_mem_valid      <= 1'b0;
      r_mem_reg_write  <= 1'b0;
      r_mem_mem_read   <= 1'b0;
      r_mem_mem_write  <= 1'b0;
    end else if (stall) begin
      r_redirect_valid <= 1'b0;
    end else begin
      r_redirect_valid <= w_redirect;
      if (w_redirect) begin
        r_redirect_pc <= w_target;
      end

      // A redirect marks the next EX instruction as wrong-path; the first
      // valid unstalled instruction while marked is dropped and clears it.
      if (w_redirect) begin
        r_squash_pending <= 1'b1;
      end else if (r_squash_pending && ex_valid) begin
        r_squash_pending <= 1'b0;
      end

      r_mem_valid     <= w_accept;
      r_mem_reg_write <= w_accept & ex_reg_write;
      r_mem_mem_read  <= w_accept & ex_mem_read;
      r_mem_mem_write <= w_accept & ex_mem_write;
      if (w_accept) begin
        r_mem_result     <= w_result;
        r_mem_store_data <= ex_store_data;
        r_mem_rd         <= ex_rd;
        r_mem_funct3     <= ex_funct3;
      end
    end
  end

  assign ex_ready       = ~stall;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign mem_valid      = r_mem_valid;
  assign mem_result     = r_mem_result;
  assign mem_store_data = r_mem_store_data;
  assign mem_rd         = r_mem_rd;
  assign mem_funct3     = r_mem_funct3;
  assign mem_reg_write  = r_mem_reg_write;
  assign mem_mem_read   = r_mem_mem_read;
  assign mem_mem_write  = r_mem_mem_write;

endmodule

// File: doc/ex_branch_stage.md
# ex_branch_stage

Execute-to-memory boundary stage of the pipelined RISC-V core, directly downstream of the ALU. It consumes the ALU result and flags, resolves conditional branches and jumps, and issues a registered one-cycle PC redirect. It selects the write-back value (ALU result or PC+4) and holds the EX/MEM pipeline register with stall, flush and wrong-path squash control.

## Interface
- WORD_SIZE, 32, datapath and PC width
- REG_ADDR, 5, destination register index width

Clock is `clk`. Reset is `rst`, **synchronous, active-high**.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  EX holds a valid instruction
- ex_pc  in  WORD_SIZE  PC of the EX instruction
- ex_imm  in  WORD_SIZE  sign-extended immediate
- alu_out  in  WORD_SIZE  ALU result
- alu_zero_flag  in  1  ALU result is zero
- alu_lt  in  1  ALU less-than; valid only under SLT/SLTU select
- ex_branch, ex_jal, ex_jalr  in  1 each  instruction class; at most one set
- ex_funct3  in  3  branch condition / memory access size
- ex_rd  in  REG_ADDR  destination register
- ex_reg_write, ex_mem_read, ex_mem_write  in  1 each  control bits
- ex_store_data  in  WORD_SIZE  rs2 value for stores
- stall  in  1  MEM cannot accept; hold everything
- flush  in  1  kill EX instruction and MEM register (trap/external)
- ex_ready  out  1  = !stall
- redirect_valid  out  1  one-cycle pulse: fetch from redirect_pc
- redirect_pc  out  WORD_SIZE  redirect target
- mem_valid  out  1  MEM register holds a valid instruction
- mem_result  out  WORD_SIZE  ALU result, or PC+4 for JAL/JALR
- mem_store_data  out  WORD_SIZE  registered ex_store_data
- mem_rd  out  REG_ADDR  registered ex_rd
- mem_funct3  out  3  registered ex_funct3
- mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  registered controls, forced 0 when !mem_valid

## Operation
- Accept = ex_valid & !stall & !flush & !squash_pending. Only an accepted instruction loads the MEM register and may redirect.
- Branch condition. Decode selects SUB for BEQ/BNE and SLT/SLTU for the rest.
  - 000 BEQ: taken = alu_zero_flag
  - 001 BNE: taken = !alu_zero_flag
  - 100 BLT / 110 BLTU: taken = alu_lt
  - 101 BGE / 111 BGEU: taken = !alu_lt
  - 010, 011: not taken, no error
- Targets, all modulo 2^WORD_SIZE and computed with the block's own adders:
  - branch and JAL: ex_pc + ex_imm
  - JALR: alu_out with bit 0 cleared (ALU computes rs1+imm)
- redirect = accept & (ex_jal | ex_jalr | (ex_branch & taken)).
- mem_result = ex_pc + 4 for JAL/JALR, otherwise alu_out.
- Branches write no register. Their mem_reg_write is whatever decode supplied, which is 0.
- Squash:
  - A redirect sets squash_pending.
  - While squash_pending is set, the first cycle with ex_valid & !stall discards that wrong-path instruction and clears the flag. mem_valid goes to 0 at the next edge.
  - flush also clears squash_pending.
  - Stalled cycles neither discard nor clear.
- stall: MEM register and squash_pending hold their values; redirect_valid is 0.
- flush: wins over stall and accept. mem_valid becomes 0 at the next edge and no redirect is issued.

## Timing
- Latency is 1 cycle. For an instruction accepted at edge N-1→N, mem_* and redirect_valid/redirect_pc are valid during cycle N.
- redirect_valid is high for exactly one cycle per redirecting instruction. redirect_pc holds its last value when redirect_valid is low.
- Two redirecting instructions cannot be back-to-back, because the second one is always squashed.
- Reset, at the next edge while rst is high: mem_valid=0, all mem_* = 0, redirect_valid=0, redirect_pc=0, squash_pending=0.
- Reset mid-operation drops any in-flight instruction and any pending squash. rst overrides stall and flush.
- ex_ready is combinational from stall. All other outputs are registered.

## Test plan
- BEQ at ex_pc=0x100, ex_imm=0x20, alu_zero_flag=1 -> next cycle redirect_valid=1, redirect_pc=0x120, mem_valid=1, mem_reg_write=0. Following EX instruction discarded (mem_valid=0 one cycle later).
- BGEU with alu_lt=1 -> no redirect. BLT with alu_lt=1, ex_pc=0xFFFFFFF0, ex_imm=0x20 -> redirect_pc=0x10 (wrap-around).
- JALR: alu_out=0x2005, ex_pc=0x40, ex_rd=1 -> redirect_pc=0x2004, mem_result=0x44, mem_rd=1, mem_reg_write=1.
- Stall held 3 cycles after a taken JAL, with ex_valid=1 throughout -> MEM register and squash_pending unchanged. First unstalled cycle discards the EX instruction. The next instruction is accepted normally.
- stall=1 and flush=1 in the same cycle -> mem_valid=0 at the next edge, no redirect_valid. flush asserted while squash_pending=1 -> next instruction accepted.
- rst asserted one cycle after a taken-branch accept -> all outputs 0 at the next edge and squash_pending cleared. The first instruction after reset is accepted.
